servo_sequencer: RTL and testbench

SERVO_SEQUENCER -- requirements
Module: servo_sequencer

---
 rtl/servo_pkg.sv | 26 ++
 rtl/servo_pwm_ch.sv | 64 ++++++
 rtl/servo_sequencer.sv | 135 +++++++++++++
 tb/tb_servo_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared FSM states, mode encodings and tick conversion helpers
package servo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_MOVE,
        ST_HOLD
    } state_t;

    localparam logic [1:0] MODE_STOP   = 2'b00;
    localparam logic [1:0] MODE_SINGLE = 2'b01;
    localparam logic [1:0] MODE_LOOP   = 2'b10;
    localparam logic [1:0] MODE_MANUAL = 2'b11;

    function automatic int us_to_ticks(input int clk_hz, input int us);
        return (clk_hz / 1_000_000) * us;
    endfunction

    // Ticks per position code, rounded down so full scale never exceeds max_ticks
    function automatic int pulse_scale(input int min_ticks, input int max_ticks, input int data_width);
        return (max_ticks - min_ticks) / ((2 ** data_width) - 1);
    endfunction

endpackage

// File: rtl/servo_pwm_ch.sv
// rtl/servo_pwm_ch.sv - one servo channel: target register, slew limiter, pulse latch and PWM compare
module servo_pwm_ch #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 20,
    parameter int MIN_TICKS  = 50000,
    parameter int SCALE      = 196,
    parameter int SLEW       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  frame_tick,
    input  logic                  move_en,
    input  logic                  tgt_load,
    input  logic [DATA_WIDTH-1:0] tgt_in,
    input  logic [CNT_WIDTH-1:0]  cnt,
    output logic                  settled,
    output logic                  pwm
);

    localparam logic [DATA_WIDTH-1:0] MID       = DATA_WIDTH'(2 ** (DATA_WIDTH - 1));
    localparam logic [DATA_WIDTH:0]   SLEW_C    = (DATA_WIDTH + 1)'(SLEW);
    localparam logic [CNT_WIDTH-1:0]  PULSE_MID = CNT_WIDTH'(MIN_TICKS + (2 ** (DATA_WIDTH - 1)) * SCALE);

    logic [DATA_WIDTH-1:0] pos;
    logic [DATA_WIDTH-1:0] tgt;
    logic [DATA_WIDTH-1:0] pos_next;
    logic [DATA_WIDTH-1:0] diff;
    logic [DATA_WIDTH-1:0] delta;
    logic [CNT_WIDTH-1:0]  pulse;
    logic [CNT_WIDTH-1:0]  pulse_next;

    always_comb begin
        diff     = (tgt > pos) ? tgt - pos : pos - tgt;
        delta    = ({1'b0, diff} > SLEW_C) ? SLEW_C[DATA_WIDTH-1:0] : diff;
        pos_next = pos;
        if (move_en) begin
            pos_next = (tgt > pos) ? pos + delta : pos - delta;
        end
    end

    // Width follows the post-slew position so the new pulse starts in the same frame
    assign pulse_next = CNT_WIDTH'(MIN_TICKS) + CNT_WIDTH'(pos_next) * CNT_WIDTH'(SCALE);
    assign settled    = (pos_next == tgt);

    always_ff @(posedge clk) begin
        if (rst) begin
            pos   <= MID;
            tgt   <= MID;
            pulse <= PULSE_MID;
            pwm   <= 1'b0;
        end else begin
            if (tgt_load) begin
                tgt <= tgt_in;
            end
            if (frame_tick) begin
                pos   <= pos_next;
                pulse <= pulse_next;
            end
            pwm <= en && (cnt < pulse);
        end
    end

endmodule

// File: rtl/servo_sequencer.sv
// rtl/servo_sequencer.sv - waypoint playback sequencer driving NUM_CH slew-limited servo PWM channels
module servo_sequencer
    import servo_pkg::*;
#(
    parameter int NUM_CH          = 3,
    parameter int DATA_WIDTH      = 8,
    parameter int ADDR_WIDTH      = 8,
    parameter int CLK_HZ          = 50_000_000,
    parameter int FRAME_US        = 20000,
    parameter int MIN_US          = 1000,
    parameter int MAX_US          = 2000,
    parameter int FRAMES_PER_STEP = 25,
    parameter int SLEW            = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        seq_len,
    input  logic [NUM_CH*DATA_WIDTH-1:0] manual_pos,
    output logic [ADDR_WIDTH-1:0]        rom_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] rom_data,
    output logic [NUM_CH-1:0]            pwm_out,
    output logic                         busy,
    output logic                         done
);

    localparam int FRAME_TICKS = us_to_ticks(CLK_HZ, FRAME_US);
    localparam int MIN_TICKS   = us_to_ticks(CLK_HZ, MIN_US);
    localparam int MAX_TICKS   = us_to_ticks(CLK_HZ, MAX_US);
    localparam int SCALE       = pulse_scale(MIN_TICKS, MAX_TICKS, DATA_WIDTH);
    localparam int CNT_WIDTH   = $clog2(FRAME_TICKS + 1);
    localparam int HOLD_W      = $clog2(FRAMES_PER_STEP + 1);

    state_t                         state;
    logic [CNT_WIDTH-1:0]           frame_cnt;
    logic [HOLD_W-1:0]              hold_cnt;
    logic                           frame_tick;
    logic                           move_en;
    logic                           tgt_load;
    logic [NUM_CH*DATA_WIDTH-1:0]   tgt_src;
    logic [NUM_CH-1:0]              settled;

    assign frame_tick = (frame_cnt == '0);
    // Stop freezes the servos where they are; every other mode keeps slewing
    assign move_en    = (mode != MODE_STOP);
    assign tgt_load   = (mode == MODE_MANUAL) || (state == ST_LOAD);
    assign tgt_src    = (mode == MODE_MANUAL) ? manual_pos : rom_data;

    always_ff @(posedge clk) begin
        if (rst || frame_cnt == CNT_WIDTH'(FRAME_TICKS - 1)) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        servo_pwm_ch #(
            .DATA_WIDTH (DATA_WIDTH),
            .CNT_WIDTH  (CNT_WIDTH),
            .MIN_TICKS  (MIN_TICKS),
            .SCALE      (SCALE),
            .SLEW       (SLEW)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .en         (en),
            .frame_tick (frame_tick),
            .move_en    (move_en),
            .tgt_load   (tgt_load),
            .tgt_in     (tgt_src[i*DATA_WIDTH +: DATA_WIDTH]),
            .cnt        (frame_cnt),
            .settled    (settled[i]),
            .pwm        (pwm_out[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rom_addr <= '0;
            hold_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (mode == MODE_STOP || mode == MODE_MANUAL) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            rom_addr <= '0;
                            state    <= ST_FETCH;
                            busy     <= 1'b1;
                        end
                    end
                    ST_FETCH: state <= ST_LOAD;
                    ST_LOAD:  state <= ST_MOVE;
                    ST_MOVE: begin
                        if (frame_tick && (&settled)) begin
                            state    <= ST_HOLD;
                            hold_cnt <= '0;
                        end
                    end
                    ST_HOLD: begin
                        if (frame_tick) begin
                            if (hold_cnt == HOLD_W'(FRAMES_PER_STEP - 1)) begin
                                hold_cnt <= '0;
                                if (rom_addr < seq_len) begin
                                    rom_addr <= rom_addr + 1'b1;
                                    state    <= ST_FETCH;
                                end else if (mode == MODE_LOOP) begin
                                    rom_addr <= '0;
                                    state    <= ST_FETCH;
                                end else begin
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                    state <= ST_IDLE;
                                end
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_servo_sequencer.sv
// tb/tb_servo_sequencer.sv - scoreboard bench: 300-tick frames, pulse = 20 + pos, slew 16, hold 2 frames
module tb_servo_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic        start;
    logic [7:0]  seq_len;
    logic [23:0] manual_pos;
    logic [7:0]  rom_addr;
    logic [23:0] rom_data;
    logic [2:0]  pwm_out;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    servo_sequencer #(
        .NUM_CH          (3),
        .DATA_WIDTH      (8),
        .ADDR_WIDTH      (8),
        .CLK_HZ          (1_000_000),
        .FRAME_US        (300),
        .MIN_US          (20),
        .MAX_US          (275),
        .FRAMES_PER_STEP (2),
        .SLEW            (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .start      (start),
        .seq_len    (seq_len),
        .manual_pos (manual_pos),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .pwm_out    (pwm_out),
        .busy       (busy),
        .done       (done)
    );

    logic [23:0] rom [0:3];
    always @(posedge clk) rom_data <= rom[rom_addr[1:0]];

    typedef struct { int w0; int w1; int w2; } pw_t;
    typedef struct { bit is_done; int addr; } ev_t;
    pw_t pw_q[$];
    ev_t ev_q[$];
    int  total = 0;
    int  bad   = 0;

    initial begin : monitor
        int   cnt [3];
        int   ew  [3];
        bit   armed;
        bit   prev0;
        logic [7:0] prev_addr;
        pw_t  pe;
        ev_t  ev;
        armed = 0;
        prev0 = 0;
        prev_addr = 8'd0;
        for (int c = 0; c < 3; c++) cnt[c] = 0;
        forever begin
            @(negedge clk);
            if (pwm_out[0] && !prev0) begin
                if (armed && pw_q.size() > 0) begin
                    pe = pw_q.pop_front();
                    ew[0] = pe.w0; ew[1] = pe.w1; ew[2] = pe.w2;
                    for (int c = 0; c < 3; c++) begin
                        total++;
                        if (cnt[c] != ew[c]) begin
                            bad++;
                            $display("FAIL pulse_width ch%0d: got %0d required %0d", c, cnt[c], ew[c]);
                        end
                    end
                end
                armed = (pw_q.size() > 0);
                for (int c = 0; c < 3; c++) cnt[c] = pwm_out[c] ? 1 : 0;
            end else begin
                for (int c = 0; c < 3; c++) if (pwm_out[c]) cnt[c]++;
            end
            prev0 = pwm_out[0];

            if (!rst && rom_addr != prev_addr) begin
                total++;
                if (ev_q.size() == 0) begin
                    bad++;
                    $display("FAIL addr_event: got unexpected rom_addr %0d required no change", rom_addr);
                end else begin
                    ev = ev_q.pop_front();
                    if (ev.is_done || ev.addr != int'(rom_addr)) begin
                        bad++;
                        $display("FAIL addr_event: got rom_addr %0d required done=%0d addr=%0d", rom_addr, ev.is_done, ev.addr);
                    end
                end
            end
            prev_addr = rom_addr;

            if (!rst && done) begin
                total++;
                if (ev_q.size() == 0) begin
                    bad++;
                    $display("FAIL done_event: got unexpected done required none");
                end else begin
                    ev = ev_q.pop_front();
                    if (!ev.is_done) begin
                        bad++;
                        $display("FAIL done_event: got done required addr %0d", ev.addr);
                    end
                end
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_at_done: got %0d required 0", busy);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic push_pw(input int a, input int b, input int c, input int n);
        pw_t e;
        e.w0 = a; e.w1 = b; e.w2 = c;
        repeat (n) pw_q.push_back(e);
    endtask

    task automatic push_ev(input bit is_done, input int addr);
        ev_t e;
        e.is_done = is_done;
        e.addr = addr;
        ev_q.push_back(e);
    endtask

    task automatic wait_rise(input int n);
        bit p;
        int seen;
        int guard;
        seen = 0;
        guard = 0;
        @(negedge clk);
        p = pwm_out[0];
        while (seen < n && guard < 300 * n + 600) begin
            @(negedge clk);
            guard++;
            if (pwm_out[0] && !p) seen++;
            p = pwm_out[0];
        end
        if (seen < n) check("frame_wait_timeout", seen, n);
    endtask

    task automatic wait_pw_empty(input int limit);
        int g;
        g = 0;
        while (pw_q.size() > 0 && g < limit) begin
            @(negedge clk);
            g++;
        end
        if (pw_q.size() > 0) begin
            check("pulse_queue_timeout", pw_q.size(), 0);
            pw_q.delete();
        end
    endtask

    task automatic wait_ev_empty(input int limit);
        int g;
        g = 0;
        while (ev_q.size() > 0 && g < limit) begin
            @(negedge clk);
            g++;
        end
        if (ev_q.size() > 0) begin
            check("event_queue_timeout", ev_q.size(), 0);
            ev_q.delete();
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        rom[0] = {8'd30, 8'd20, 8'd10};
        rom[1] = {8'd200, 8'd200, 8'd200};
        rom[2] = {8'd0, 8'd0, 8'd0};
        rom[3] = 24'd0;
        rst = 1'b1; en = 1'b1; mode = 2'b00; start = 1'b0;
        seq_len = 8'd0; manual_pos = 24'd0;
        step(3);
        check("reset_pwm", int'(pwm_out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_rom_addr", int'(rom_addr), 0);
        rst = 1'b0;

        // Stop mode: mid-scale 128 -> 148 ticks on every channel
        push_pw(148, 148, 148, 2);
        wait_pw_empty(2000);

        // Manual slew of ch0 toward 255, capped at full scale
        wait_rise(1);
        step(1);
        mode = 2'b11;
        manual_pos = {8'd128, 8'd128, 8'd255};
        push_pw(164, 148, 148, 1);
        push_pw(180, 148, 148, 1);
        push_pw(196, 148, 148, 1);
        push_pw(212, 148, 148, 1);
        push_pw(228, 148, 148, 1);
        push_pw(244, 148, 148, 1);
        push_pw(260, 148, 148, 1);
        push_pw(275, 148, 148, 2);
        wait_pw_empty(4000);

        // Single play over three waypoints
        mode = 2'b01;
        seq_len = 8'd2;
        push_ev(0, 1);
        push_ev(0, 2);
        push_ev(1, 0);
        pulse_start();
        step(1);
        check("busy_single", int'(busy), 1);
        wait_ev_empty(25000);
        push_pw(20, 20, 20, 1);
        wait_pw_empty(1000);

        // Loop over two waypoints, then abort
        mode = 2'b10;
        seq_len = 8'd1;
        push_ev(0, 0);
        push_ev(0, 1);
        push_ev(0, 0);
        push_ev(0, 1);
        pulse_start();
        wait_ev_empty(20000);
        mode = 2'b00;
        step(2);
        check("busy_loop_abort", int'(busy), 0);

        // Abort during MOVE freezes positions; start while busy is ignored
        mode = 2'b01;
        seq_len = 8'd2;
        push_ev(0, 0);
        push_ev(0, 1);
        pulse_start();
        wait_ev_empty(6000);
        pulse_start();
        wait_rise(3);
        step(1);
        mode = 2'b00;
        push_pw(78, 88, 98, 2);
        wait_pw_empty(1500);
        pulse_start();
        step(2);
        check("start_in_stop_busy", int'(busy), 0);
        check("abort_rom_addr", int'(rom_addr), 1);

        // Reset while holding waypoint 0
        push_ev(0, 0);
        wait_rise(1);
        step(1);
        mode = 2'b01;
        pulse_start();
        wait_ev_empty(100);
        wait_rise(4);
        step(1);
        check("busy_in_hold", int'(busy), 1);
        rst = 1'b1;
        step(1);
        check("rst_hold_rom_addr", int'(rom_addr), 0);
        check("rst_hold_busy", int'(busy), 0);
        check("rst_hold_done", int'(done), 0);
        check("rst_hold_pwm", int'(pwm_out), 0);
        rst = 1'b0;
        push_pw(148, 148, 148, 1);
        wait_pw_empty(1500);

        // en low holds outputs at zero
        mode = 2'b00;
        en = 1'b0;
        step(2);
        begin
            int highs;
            highs = 0;
            for (int i = 0; i < 320; i++) begin
                step(1);
                if (pwm_out != 3'b000) highs++;
            end
            check("en_low_pwm_high_cycles", highs, 0);
        end
        en = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
